// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_frame_pkg
//  Purpose : Shared definitions for the UART frame decoder: decoder state
//            encoding, error code values and the default start-of-frame byte.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TYPE    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/byte_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module  : byte_timeout_timer
//  Purpose : Counts idle cycles between byte strobes and flags expiry once
//            TIMEOUT_CYCLES-1 idle cycles have elapsed. Held at zero while
//            disabled.
//  Ports   : clock  - system clock
//            reset  - asynchronous active-low reset
//            clear  - restart the count (a byte arrived)
//            enable - count while high, hold at zero while low
//            expire - high while the count sits at its terminal value
//  Rev     : 1.0  initial release
// ============================================================================
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 200000   // must be >= 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (count != LAST) begin
      // Saturate: the owner is expected to leave the enabled state on expiry.
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : uart_frame_decoder
//  Purpose : Assembles the UART receiver byte stream into framed packets
//            (HEADER, TYPE, LEN, payload, XOR checksum), validates length,
//            checksum and inter-byte timing, and presents good frames on a
//            valid/ready output register. Errors are reported on a one-cycle
//            strobe.
//  Ports   : clock, reset(active-low async)
//            rx_valid/rx_data          - byte strobe from the UART receiver
//            frame_valid/frame_ready   - output handshake
//            frame_type/len/payload    - held frame contents
//            err_valid/err_code        - one-cycle error report
//            busy                      - decoder is inside a frame
//  Rev     : 1.0  initial release
// ============================================================================
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 8,        // 1..15
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] HEADER         = DEFAULT_HEADER
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [7:0]               frame_type,
  output logic [3:0]               frame_len,
  output logic [8*MAX_PAYLOAD-1:0] frame_payload,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic                     busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_PAYLOAD);

  state_t                   state;
  logic [7:0]               typ;
  logic [3:0]               len;
  logic [3:0]               idx;
  logic [7:0]               chk;
  logic [8*MAX_PAYLOAD-1:0] pbuf;
  logic                     expire;

  assign busy = (state != IDLE);

  byte_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (busy),
    .expire (expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      typ           <= '0;
      len           <= '0;
      idx           <= '0;
      chk           <= '0;
      pbuf          <= '0;
      frame_valid   <= 1'b0;
      frame_type    <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
      err_valid     <= 1'b0;
      err_code      <= '0;
    end else begin
      err_valid <= 1'b0;
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;   // a load below in the same cycle overrides this
      end

      case (state)
        IDLE: begin
          if (rx_valid && rx_data == HEADER) begin
            // Clearing the buffer up front keeps unused payload bytes zero.
            pbuf  <= '0;
            chk   <= '0;
            state <= TYPE;
          end
        end

        TYPE: begin
          if (rx_valid) begin
            typ   <= rx_data;
            chk   <= rx_data;
            state <= LEN;
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end

        LEN: begin
          if (rx_valid) begin
            chk <= chk ^ rx_data;
            if (rx_data > MAX_LEN_B) begin
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= IDLE;
            end else begin
              len   <= rx_data[3:0];
              idx   <= '0;
              state <= (rx_data == 8'd0) ? CHECK : PAYLOAD;
            end
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end

        PAYLOAD: begin
          if (rx_valid) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
              if (idx == 4'(i)) pbuf[8*i +: 8] <= rx_data;
            end
            chk <= chk ^ rx_data;
            idx <= idx + 4'd1;
            if (idx + 4'd1 == len) state <= CHECK;
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end

        CHECK: begin
          if (rx_valid) begin
            if (rx_data != chk) begin
              err_valid <= 1'b1;
              err_code  <= ERR_CHK;
            end else if (!frame_valid || frame_ready) begin
              frame_valid   <= 1'b1;
              frame_type    <= typ;
              frame_len     <= len;
              frame_payload <= pbuf;
            end else begin
              // Held frame not yet consumed: the new frame is lost.
              err_valid <= 1'b1;
              err_code  <= ERR_OVERRUN;
            end
            state <= IDLE;
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_frame_decoder
//  Purpose : Self-checking bench for uart_frame_decoder: directed vector
//            table, hand-written handshake/timeout/reset sequences and
//            randomized frames checked against a frame-level parser model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_frame_decoder;

  localparam int MAXP = 8;
  localparam int TMO  = 50;
  localparam logic [7:0] HDR = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          frame_ready = 1'b0;
  logic          frame_valid;
  logic [7:0]    frame_type;
  logic [3:0]    frame_len;
  logic [63:0]   frame_payload;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          busy;

  uart_frame_decoder #(
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TMO),
    .HEADER         (HDR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_type    (frame_type),
    .frame_len     (frame_len),
    .frame_payload (frame_payload),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: observes outputs on the falling edge.
  int          err_n, fv_n, err_cyc;
  logic [1:0]  last_err;
  logic [7:0]  cap_type;
  logic [3:0]  cap_len;
  logic [63:0] cap_pl;

  always @(negedge clock) begin
    if (err_valid) begin
      err_n    = err_n + 1;
      last_err = err_code;
      err_cyc  = cyc;
    end
    if (frame_valid) begin
      fv_n     = fv_n + 1;
      cap_type = frame_type;
      cap_len  = frame_len;
      cap_pl   = frame_payload;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    err_n = 0; fv_n = 0; err_cyc = -1; last_err = 2'd0;
    cap_type = '0; cap_len = '0; cap_pl = '0;
  endtask

  // Called just after a rising edge; strobes one byte for one cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain(input string name);
    if (frame_valid) begin
      frame_ready = 1'b1;
      @(posedge clock); #1;
      frame_ready = 1'b0;
      chk({name, "_drain"}, 64'(frame_valid), 64'd0);
    end
  endtask

  task automatic verify(input string name, input int exp_err, input logic exp_fv,
                        input logic [7:0] t, input logic [3:0] l, input logic [63:0] pl,
                        input logic ready);
    chk({name, "_errcnt"}, 64'(err_n), (exp_err >= 0) ? 64'd1 : 64'd0);
    if (exp_err >= 0) chk({name, "_errcode"}, 64'(last_err), 64'(exp_err));
    if (exp_fv) begin
      if (ready) chk({name, "_fvcycles"}, 64'(fv_n), 64'd1);
      else       chk({name, "_fvheld"}, 64'(frame_valid), 64'd1);
      chk({name, "_type"}, 64'(cap_type), 64'(t));
      chk({name, "_len"},  64'(cap_len),  64'(l));
      chk({name, "_pl"},   cap_pl, pl);
    end else begin
      chk({name, "_nofv"}, 64'(fv_n), 64'd0);
    end
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Directed vectors: byte string right-aligned, first byte most significant.
  typedef struct {
    string        name;
    logic [127:0] bytes;
    int           n;
    logic         ready;
    int           exp_err;
    logic         exp_fv;
    logic [7:0]   exp_type;
    logic [3:0]   exp_len;
    logic [63:0]  exp_pl;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input string nm, input logic [127:0] b, input int n, input logic rdy,
                         input int e, input logic fv, input logic [7:0] t,
                         input logic [3:0] l, input logic [63:0] pl);
    vec_t v;
    v.name = nm; v.bytes = b; v.n = n; v.ready = rdy; v.exp_err = e;
    v.exp_fv = fv; v.exp_type = t; v.exp_len = l; v.exp_pl = pl;
    tbl.push_back(v);
  endtask

  // Frame-level reference: scan for the header, then apply the format rules.
  task automatic ref_decode(input logic [7:0] q[$], output int e, output logic fv,
                            output logic [7:0] t, output logic [3:0] l, output logic [63:0] pl);
    int p;
    logic [7:0] lb, x;
    p = 0; e = -1; fv = 1'b0; t = '0; l = '0; pl = '0;
    while (p < q.size() && q[p] != HDR) p++;
    p++;
    t = q[p]; p++;
    lb = q[p]; p++;
    if (int'(lb) > MAXP) begin
      e = 1;
    end else begin
      x = t ^ lb;
      for (int i = 0; i < int'(lb); i++) begin
        pl[8*i +: 8] = q[p];
        x = x ^ q[p];
        p++;
      end
      if (q[p] != x) e = 2;
      else begin fv = 1'b1; l = lb[3:0]; end
    end
  endtask

  initial begin
    int         k;
    logic [7:0] q[$];
    int         e;
    logic       fv;
    logic [7:0] t, typ, lenb, x;
    logic [3:0] l;
    logic [63:0] pl;

    clear_mon();
    #2;
    chk("rst_fv",   64'(frame_valid),  64'd0);
    chk("rst_err",  64'(err_valid),    64'd0);
    chk("rst_busy", 64'(busy),         64'd0);
    chk("rst_type", 64'(frame_type),   64'd0);
    chk("rst_len",  64'(frame_len),    64'd0);
    chk("rst_pl",   frame_payload,     64'd0);
    idle(3);
    reset = 1'b1;
    idle(2);

    add_vec("good",  {8'hA5, 8'h02, 8'h02, 8'h11, 8'h22, 8'h33}, 6, 1'b1, -1, 1'b1, 8'h02, 4'd2, 64'h2211);
    add_vec("zlen",  {8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h07}, 6, 1'b1, -1, 1'b1, 8'h07, 4'd0, 64'h0);
    add_vec("badchk",{8'hA5, 8'h02, 8'h02, 8'h11, 8'h22, 8'h34}, 6, 1'b1,  2, 1'b0, 8'h00, 4'd0, 64'h0);
    add_vec("badlen",{8'hA5, 8'h01, 8'h09},                     3, 1'b1,  1, 1'b0, 8'h00, 4'd0, 64'h0);
    add_vec("after", {8'hA5, 8'h01, 8'h01, 8'h55, 8'h55},       5, 1'b0, -1, 1'b1, 8'h01, 4'd1, 64'h55);
    add_vec("maxlen",{8'hA5, 8'h10, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10},
            12, 1'b1, -1, 1'b1, 8'h10, 4'd8, 64'h0807060504030201);

    foreach (tbl[i]) begin
      frame_ready = tbl[i].ready;
      clear_mon();
      for (int j = 0; j < tbl[i].n; j++) begin
        send_byte(tbl[i].bytes[8*(tbl[i].n-1-j) +: 8]);
        idle(1);
      end
      idle(2);
      verify(tbl[i].name, tbl[i].exp_err, tbl[i].exp_fv, tbl[i].exp_type,
             tbl[i].exp_len, tbl[i].exp_pl, tbl[i].ready);
      frame_ready = 1'b0;
      drain(tbl[i].name);
    end

    // Overrun: second good frame while the first is still held.
    frame_ready = 1'b0;
    clear_mon();
    q = '{8'hA5, 8'h02, 8'h02, 8'h11, 8'h22, 8'h33};
    foreach (q[i]) send_byte(q[i]);
    idle(2);
    q = '{8'hA5, 8'h04, 8'h01, 8'h66, 8'h63};
    foreach (q[i]) send_byte(q[i]);
    idle(2);
    chk("ovr_errcnt", 64'(err_n), 64'd1);
    chk("ovr_code",   64'(last_err), 64'd0);
    chk("ovr_fv",     64'(frame_valid), 64'd1);
    chk("ovr_type",   64'(frame_type), 64'h02);
    chk("ovr_len",    64'(frame_len), 64'd2);
    chk("ovr_pl",     frame_payload, 64'h2211);

    // Accept and load in the same cycle: no overrun, new frame replaces old.
    clear_mon();
    q = '{8'hA5, 8'h04, 8'h01, 8'h66};
    foreach (q[i]) send_byte(q[i]);
    frame_ready = 1'b1;
    send_byte(8'h63);
    frame_ready = 1'b0;
    idle(1);
    chk("swap_errcnt", 64'(err_n), 64'd0);
    chk("swap_fv",     64'(frame_valid), 64'd1);
    chk("swap_type",   64'(frame_type), 64'h04);
    chk("swap_len",    64'(frame_len), 64'd1);
    chk("swap_pl",     frame_payload, 64'h66);
    drain("swap");

    // Timeout: error exactly TMO edges after the edge that took the last byte.
    clear_mon();
    send_byte(8'hA5);
    k = cyc;
    send_byte(8'h03);
    idle(TMO + 5);
    chk("tmo_errcnt", 64'(err_n), 64'd1);
    chk("tmo_code",   64'(last_err), 64'd3);
    chk("tmo_cycle",  64'(err_cyc - (k + 1)), 64'(TMO));
    chk("tmo_busy",   64'(busy), 64'd0);

    // Byte arriving in the expiry cycle wins.
    clear_mon();
    frame_ready = 1'b0;
    send_byte(8'hA5);
    k = cyc;
    send_byte(8'h03);
    idle(TMO - 1);
    chk("tie_when",   64'(cyc - k), 64'(TMO));
    send_byte(8'h00);
    send_byte(8'h03);
    idle(2);
    verify("tie", -1, 1'b1, 8'h03, 4'd0, 64'h0, 1'b0);

    // Mid-frame reset while a frame is held: everything clears at once.
    q = '{8'hA5, 8'h02, 8'h04, 8'h11, 8'h22};
    foreach (q[i]) send_byte(q[i]);
    clear_mon();
    chk("mrst_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #2;
    chk("mrst_fv",   64'(frame_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_type", 64'(frame_type), 64'd0);
    chk("mrst_pl",   frame_payload, 64'd0);
    idle(2);
    reset = 1'b1;
    idle(3);
    chk("mrst_noerr", 64'(err_n), 64'd0);
    chk("mrst_busy2", 64'(busy), 64'd0);

    // Randomized frames against the parser model.
    frame_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      q = {};
      for (int m = 0; m < int'($urandom_range(0, 2)); m++) begin
        x = 8'($urandom);
        q.push_back((x == HDR) ? 8'h5A : x);
      end
      typ  = 8'($urandom);
      lenb = 8'($urandom_range(0, 10));
      q.push_back(HDR); q.push_back(typ); q.push_back(lenb);
      if (int'(lenb) <= MAXP) begin
        x = typ ^ lenb;
        for (int m = 0; m < int'(lenb); m++) begin
          t = 8'($urandom);
          q.push_back(t);
          x = x ^ t;
        end
        if ($urandom_range(0, 3) == 0) x = x ^ (8'd1 << $urandom_range(0, 7));
        q.push_back(x);
      end
      ref_decode(q, e, fv, t, l, pl);
      clear_mon();
      foreach (q[i]) begin
        send_byte(q[i]);
        idle(int'($urandom_range(0, 3)));
      end
      idle(3);
      verify($sformatf("rnd%0d", f), e, fv, t, l, pl, 1'b1);
    end
    frame_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
